// File: rtl/pe_array_out_collector_if.sv
// Stream bundle between pe_array_bd, the output collector and the host/DMA side.
// master is the collector's view; slave is the environment's view.
interface pe_array_out_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
);
  logic                      din_v;
  logic [DATA_WIDTH*2-1:0]   din;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_WIDTH*2-1:0]   m_data;
  logic                      m_last;
  logic [$clog2(DEPTH):0]    level;
  logic                      overflow;
  logic [15:0]               frame_cnt;

  modport master (
    input  din_v, din, m_ready,
    output m_valid, m_data, m_last, level, overflow, frame_cnt
  );

  modport slave (
    output din_v, din, m_ready,
    input  m_valid, m_data, m_last, level, overflow, frame_cnt
  );
endinterface

// File: rtl/pe_array_out_collector.sv
// Buffers the backpressure-free result stream of pe_array_bd in a FIFO and
// re-emits it on a valid/ready stream with frame-end marking and overflow flag.
module pe_array_out_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int FRAME_LEN  = 512
) (
  input logic                      clk,
  input logic                      rst,
  pe_array_out_collector_if.master bus
);
  localparam int W  = DATA_WIDTH * 2;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [CW-1:0] POS_TOP = CW'(FRAME_LEN - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic [CW-1:0] words_left, words_left_adv;
  logic [W-1:0]  m_data_q;
  logic          m_valid_q, m_last_q, overflow_q;
  logic [15:0]   frame_cnt_q;
  logic          do_write, do_load, accept;

  // Fullness looks at the registered level only, so a same-cycle pop never frees a slot.
  assign do_write = bus.din_v && (level_q != FULL);
  assign do_load  = (!m_valid_q || bus.m_ready) && (level_q != '0);
  assign accept   = m_valid_q && bus.m_ready;

  // Frame position as a down-counter: zero means the word is the last of its frame.
  always_comb begin
    words_left_adv = words_left;
    if (accept)
      words_left_adv = (words_left == '0) ? POS_TOP : words_left - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      words_left  <= POS_TOP;
      frame_cnt_q <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (bus.din_v && !do_write)
        overflow_q <= 1'b1;

      if (do_write && !do_load)
        level_q <= level_q + 1'b1;
      else if (do_load && !do_write)
        level_q <= level_q - 1'b1;

      if (do_load) begin
        m_data_q  <= mem[rd_ptr];
        m_last_q  <= (words_left_adv == '0);
        m_valid_q <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (accept) begin
        m_valid_q <= 1'b0;
      end

      words_left <= words_left_adv;
      if (accept && m_last_q)
        frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_pe_array_out_collector.sv
// Directed bench for pe_array_out_collector with a queue-based reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_pe_array_out_collector;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int FLEN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_array_out_collector_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  pe_array_out_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue, one output slot, counts of loaded/accepted words.
  logic [31:0] mq[$];
  logic [31:0] md;
  bit          mv, mlast, movf;
  int          loaded, accepted;
  bit          m_acc, m_ld, m_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      md = '0; mv = 0; mlast = 0; movf = 0;
      loaded = 0; accepted = 0;
    end else begin
      m_acc = mv && bus.m_ready;
      m_ld  = (!mv || bus.m_ready) && (mq.size() > 0);
      m_wr  = bus.din_v && (mq.size() < DEPTH);
      if (bus.din_v && !m_wr) movf = 1;
      if (m_acc) accepted++;
      if (m_ld) begin
        md    = mq.pop_front();
        mlast = ((loaded % FLEN) == FLEN - 1);
        loaded++;
        mv    = 1;
      end else if (m_acc) begin
        mv = 0;
      end
      if (m_wr) mq.push_back(bus.din);
    end
  end

  always @(posedge clk) cycle++;

  // Per-cycle compare and log of delivered words.
  logic [31:0] got[$];
  bit          got_last[$];
  int          got_cyc[$];
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("m_valid", bus.m_valid, mv);
      chk("level", bus.level, mq.size());
      chk("overflow", bus.overflow, movf);
      chk("frame_cnt", bus.frame_cnt, 16'((accepted / FLEN) % 65536));
      if (mv) begin
        chk("m_data", bus.m_data, md);
        chk("m_last", bus.m_last, mlast);
      end
      if (prev_stall && bus.m_valid) begin
        chk("stall_hold_data", bus.m_data, prev_data);
        chk("stall_hold_last", bus.m_last, prev_last);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        got_cyc.push_back(cycle);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    got.delete(); got_last.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    bus.din_v = 0; bus.m_ready = 0;
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #1 rst = 0;
    clear_log();
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.din_v = 1;
      bus.din   = 32'(first + i);
      step();
    end
    bus.din_v = 0;
  endtask

  task automatic chk_seq(input string name, input int first, input int n, input int last_mask);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({name, "_data"}, got[i], 32'(first + i));
      chk({name, "_last"}, got_last[i], ((last_mask >> i) & 1) != 0);
    end
  endtask

  initial begin
    bus.din_v = 0; bus.din = '0; bus.m_ready = 0;
    @(posedge clk); #2;
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_data", bus.m_data, 0);
    chk("reset_level", bus.level, 0);
    chk("reset_frame_cnt", bus.frame_cnt, 0);
    @(posedge clk); #1 rst = 0;

    // 1: single word, two-edge latency
    do_reset();
    bus.m_ready = 1; bus.din_v = 1; bus.din = 32'h1234ABCD;
    step();
    bus.din_v = 0;
    chk("t1_valid_n", bus.m_valid, 0);
    chk("t1_level_n", bus.level, 1);
    step();
    chk("t1_valid_n1", bus.m_valid, 1);
    chk("t1_data_n1", bus.m_data, 32'h1234ABCD);
    chk("t1_last_n1", bus.m_last, 0);
    step();
    chk("t1_valid_n2", bus.m_valid, 0);
    chk("t1_level_n2", bus.level, 0);
    chk("t1_got", got.size(), 1);

    // 2: streaming 12 words, frames of 4
    do_reset();
    bus.m_ready = 1;
    feed(1, 12);
    idle(6);
    chk_seq("t2", 1, 12, 'b1000_1000_1000);
    if (got_cyc.size() == 12) chk("t2_rate", got_cyc[11] - got_cyc[0], 11);
    chk("t2_frame_cnt", bus.frame_cnt, 3);
    chk("t2_overflow", bus.overflow, 0);

    // 3: backpressure with overflow
    do_reset();
    feed(1, 12);
    chk("t3_valid", bus.m_valid, 1);
    chk("t3_data", bus.m_data, 1);
    chk("t3_level", bus.level, 8);
    chk("t3_overflow", bus.overflow, 1);
    bus.m_ready = 1;
    idle(15);
    chk_seq("t3", 1, 9, 'b0_1000_1000);
    chk("t3_overflow_sticky", bus.overflow, 1);
    chk("t3_frame_cnt", bus.frame_cnt, 2);

    // 4: ready pattern 1,0,0,1 while streaming
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.din_v   = 1;
      bus.din     = 32'(i + 1);
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    bus.din_v = 0;
    for (int i = 0; i < 8; i++) begin
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    bus.m_ready = 1;
    idle(10);
    chk_seq("t4", 1, 8, 'b1000_1000);

    // 5: full FIFO with simultaneous pop and write; then write+load at level 3
    do_reset();
    feed(1, 9);
    chk("t5_level_full", bus.level, 8);
    chk("t5_ovf_before", bus.overflow, 0);
    bus.din_v = 1; bus.din = 32'h99; bus.m_ready = 1;
    step();
    bus.din_v = 0; bus.m_ready = 0;
    chk("t5_level_after_pop", bus.level, 7);
    chk("t5_ovf_after", bus.overflow, 1);
    do_reset();
    feed(1, 4);
    chk("t5_level3", bus.level, 3);
    bus.din_v = 1; bus.din = 32'h5; bus.m_ready = 1;
    step();
    bus.din_v = 0; bus.m_ready = 0;
    chk("t5_level3_hold", bus.level, 3);
    chk("t5_data2", bus.m_data, 2);

    // 6: async reset after 6 words delivered
    do_reset();
    bus.m_ready = 1;
    for (int i = 0; i < 40 && got.size() < 6; i++) begin
      bus.din_v = (i < 10);
      bus.din   = 32'(i + 1);
      step();
    end
    bus.din_v = 0;
    chk("t6_reached_6", got.size() >= 6, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", bus.m_valid, 0);
    chk("t6_rst_data", bus.m_data, 0);
    chk("t6_rst_last", bus.m_last, 0);
    chk("t6_rst_level", bus.level, 0);
    chk("t6_rst_frame_cnt", bus.frame_cnt, 0);
    chk("t6_rst_overflow", bus.overflow, 0);
    @(posedge clk); #1 rst = 0;
    clear_log();
    feed(32'hA1, 4);
    idle(6);
    chk_seq("t6", 32'hA1, 4, 'b1000);
    chk("t6_frame_cnt", bus.frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
